mat_fetch_sched: RTL and testbench
==================================

Name: mat_fetch_sched

Overview:
Fetch sequencer between matrix BRAM and iter_control. On each new_request it reads row row_req of matrix A and column col_req of matrix B through one shared synchronous BRAM read port, one byte per cycle. It assembles both into 32-lane vectors and presents them to iter_control with a one-cycle val_rows strobe. It reuses the last fetched A row when the row index repeats, which halves port traffic for row-major iteration.

Parameters:
N, 32, maximum matrix dimension and number of vector lanes
DW, 8, element width in bits
AW, 11, BRAM address width; must satisfy 2^AW >= 2*N*N
BRAM_LAT, 2, BRAM read latency in cycles from address to data

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
new_request  input  1  one-cycle request strobe from iter_control
row_req  input  6  A row index for the request
col_req  input  6  B column index for the request
dim_in  input  6  active dimension, 1..N; 0 is illegal
flush  input  1  invalidate A-row reuse (matrices reloaded)
bram_addr  output  AW  shared read address
bram_data  input  DW  read data, valid BRAM_LAT cycles after its address
matA_row  output  N*DW  packed A row; lane k = [k*DW +: DW]
matB_col  output  N*DW  packed B column, same lane layout
val_rows  output  1  one-cycle strobe, vectors and indices valid
row_in  output  6  row index echoed with val_rows
col_in  output  6  column index echoed with val_rows
busy  output  1  high from request accept until val_rows cycle inclusive
req_dropped  output  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset (sync): all outputs 0. State IDLE. Reuse-valid cleared. In-flight tag pipeline cleared; returning data is discarded.
- Address map: A element (r,k) = r*N + k. B element (k,c) = N*N + k*N + c.
- States: IDLE, ISSUE_A, ISSUE_B, DRAIN, PRESENT.
- IDLE: on new_request with dim_in != 0:
  - Latch row, col, dim.
  - Clear both vector registers to 0.
  - busy=1.
  - Go to ISSUE_A, or to ISSUE_B if reuse-valid and row_req == last A row.
  - On a reuse skip, matA_row keeps the previously fetched row and is not cleared.
- ISSUE_A: one address per cycle for k=0..dim-1, then ISSUE_B.
- ISSUE_B: one address per cycle for k=0..dim-1, then DRAIN.
- Each issue pushes tag {valid, sel A/B, k} into a BRAM_LAT-deep shift pipeline.
- When a tag exits the pipeline, bram_data is written to lane k of the selected vector.
- DRAIN: wait until the pipeline is empty, then PRESENT.
- PRESENT: val_rows=1 for exactly one cycle with row_in/col_in. Record last A row and set reuse-valid. Next state IDLE, busy=0 next cycle.
- Lanes k >= dim are 0 in matB_col, and in matA_row whenever A was fetched.
- Latency: request sampled in cycle 0, first address in cycle 1. With F = 2*dim (or dim on reuse), val_rows is high in cycle F+BRAM_LAT+1.
- bram_addr holds its last value when not issuing (don't-care to BRAM).
- new_request while busy: ignored and req_dropped pulses. In-progress fetch is unaffected.
- new_request with dim_in == 0: req_dropped pulses, state stays IDLE.
- flush: clears reuse-valid next cycle.
  - Flush during ISSUE_A/ISSUE_B/DRAIN does not abort the current fetch, but reuse-valid remains 0 after its PRESENT.
  - Flush coincident with PRESENT also leaves reuse-valid 0.
- dim_in, row_req, col_req are sampled only at acceptance; later changes have no effect.
- row_req/col_req >= dim are not checked; the resulting addresses are issued as computed.
- Reset mid-fetch returns to IDLE within one cycle. No val_rows is produced for the aborted request.

Test Plan:
- Cold fetch, dim=3, A row1 = {2,2,2}, B col0 = {1,0,0}, request (1,0) in cycle 0:
  - Addresses 32,33,34 then 1024,1056,1088 in cycles 1..6.
  - val_rows in cycle 9 with matA lanes0-2 = 2, matB lanes0-2 = {1,0,0}, lanes 3-31 = 0, row_in=1, col_in=0.
- Reuse: request (1,1) after the fetch above:
  - Only B addresses 1025,1057,1089 are issued.
  - val_rows 6 cycles after the request; matA_row is unchanged.
- Flush then request (1,2): a full 6-address fetch, val_rows 9 cycles after the request.
- new_request during ISSUE_B and a request with dim_in=0: one req_dropped pulse each; the original val_rows timing and data are unchanged.
- dim=32, request (31,31): 64 addresses, last address 2047, val_rows in cycle 67, all 32 lanes filled.
- rst_in asserted in the DRAIN cycle: next cycle busy=0 and outputs 0. No val_rows follows. The next request (0,0) is a cold fetch with no reuse.

Source files
------------

// File: rtl/mat_fetch_sched.sv
// Fetch sequencer: reads one A row and one B column through a shared BRAM port
// and presents them as packed lane vectors to iter_control.
module mat_fetch_sched #(
  parameter int N        = 32,
  parameter int DW       = 8,
  parameter int AW       = 11,
  parameter int BRAM_LAT = 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            new_request,
  input  logic [5:0]      row_req,
  input  logic [5:0]      col_req,
  input  logic [5:0]      dim_in,
  input  logic            flush,
  output logic [AW-1:0]   bram_addr,
  input  logic [DW-1:0]   bram_data,
  output logic [N*DW-1:0] matA_row,
  output logic [N*DW-1:0] matB_col,
  output logic            val_rows,
  output logic [5:0]      row_in,
  output logic [5:0]      col_in,
  output logic            busy,
  output logic            req_dropped
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE_A, S_ISSUE_B, S_DRAIN, S_PRESENT} state_t;

  state_t                      state_q, state_d;
  logic [5:0]                  row_q, row_d, col_q, col_d, dim_q, dim_d, k_q, k_d;
  logic [5:0]                  last_row_q, last_row_d;
  logic                        reuse_q, reuse_d, flush_pend_q, flush_pend_d, drop_q, drop_d;
  logic [AW-1:0]               addr_q, addr_d, addr_calc;
  logic [N*DW-1:0]             mat_a_q, mat_a_d, mat_b_q, mat_b_d;
  logic [BRAM_LAT-1:0]         tv_q, tv_d, tb_q, tb_d;
  logic [BRAM_LAT-1:0][5:0]    tk_q, tk_d;
  logic                        issue, sel_b, pipe_busy;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    dim_d        = dim_q;
    k_d          = k_q;
    last_row_d   = last_row_q;
    reuse_d      = reuse_q;
    flush_pend_d = flush_pend_q;
    drop_d       = 1'b0;
    mat_a_d      = mat_a_q;
    mat_b_d      = mat_b_q;

    issue = (state_q == S_ISSUE_A) || (state_q == S_ISSUE_B);
    sel_b = (state_q == S_ISSUE_B);
    addr_calc = sel_b ? (AW'(N * N) + AW'(k_q) * AW'(N) + AW'(col_q))
                      : (AW'(row_q) * AW'(N) + AW'(k_q));
    addr_d = issue ? addr_calc : addr_q;

    // Tag pipeline mirrors BRAM latency so each returning byte knows its lane.
    tv_d = '0;
    tb_d = '0;
    tk_d = '0;
    tv_d[0] = issue;
    tb_d[0] = sel_b;
    tk_d[0] = k_q;
    for (int i = 1; i < BRAM_LAT; i++) begin
      tv_d[i] = tv_q[i-1];
      tb_d[i] = tb_q[i-1];
      tk_d[i] = tk_q[i-1];
    end

    // The last stage retires on this edge, so only earlier stages block PRESENT.
    pipe_busy = 1'b0;
    for (int i = 0; i < BRAM_LAT - 1; i++) begin
      pipe_busy = pipe_busy | tv_q[i];
    end

    if (tv_q[BRAM_LAT-1] && (int'(tk_q[BRAM_LAT-1]) < N)) begin
      if (tb_q[BRAM_LAT-1]) mat_b_d[int'(tk_q[BRAM_LAT-1])*DW +: DW] = bram_data;
      else                  mat_a_d[int'(tk_q[BRAM_LAT-1])*DW +: DW] = bram_data;
    end

    if (flush) begin
      reuse_d = 1'b0;
      if (issue || state_q == S_DRAIN) flush_pend_d = 1'b1;
    end

    if (new_request && state_q != S_IDLE) drop_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (new_request) begin
          if (dim_in == 6'd0) begin
            drop_d = 1'b1;
          end else begin
            row_d        = row_req;
            col_d        = col_req;
            dim_d        = dim_in;
            k_d          = 6'd0;
            flush_pend_d = 1'b0;
            mat_b_d      = '0;
            if (reuse_q && !flush && row_req == last_row_q) begin
              state_d = S_ISSUE_B;
            end else begin
              mat_a_d = '0;
              state_d = S_ISSUE_A;
            end
          end
        end
      end
      S_ISSUE_A: begin
        k_d = k_q + 6'd1;
        if (k_q == dim_q - 6'd1) begin
          k_d     = 6'd0;
          state_d = S_ISSUE_B;
        end
      end
      S_ISSUE_B: begin
        k_d = k_q + 6'd1;
        if (k_q == dim_q - 6'd1) begin
          k_d     = 6'd0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!pipe_busy) state_d = S_PRESENT;
      end
      S_PRESENT: begin
        last_row_d = row_q;
        reuse_d    = !(flush || flush_pend_q);
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      dim_q        <= '0;
      k_q          <= '0;
      last_row_q   <= '0;
      reuse_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      drop_q       <= 1'b0;
      addr_q       <= '0;
      mat_a_q      <= '0;
      mat_b_q      <= '0;
      tv_q         <= '0;
      tb_q         <= '0;
      tk_q         <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      dim_q        <= dim_d;
      k_q          <= k_d;
      last_row_q   <= last_row_d;
      reuse_q      <= reuse_d;
      flush_pend_q <= flush_pend_d;
      drop_q       <= drop_d;
      addr_q       <= addr_d;
      mat_a_q      <= mat_a_d;
      mat_b_q      <= mat_b_d;
      tv_q         <= tv_d;
      tb_q         <= tb_d;
      tk_q         <= tk_d;
    end
  end

  assign bram_addr   = issue ? addr_calc : addr_q;
  assign matA_row    = mat_a_q;
  assign matB_col    = mat_b_q;
  assign val_rows    = (state_q == S_PRESENT);
  assign row_in      = row_q;
  assign col_in      = col_q;
  assign busy        = (state_q != S_IDLE);
  assign req_dropped = drop_q;

endmodule

// File: tb/tb_mat_fetch_sched.sv
// Self-checking bench for mat_fetch_sched: directed request table, hand-built
// corner sequences and randomized requests against a BRAM-content reference model.
module tb_mat_fetch_sched;
  localparam int N = 32, DW = 8, AW = 11, LAT = 2;
  localparam int AMASK = (1 << AW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            new_request, flush;
  logic [5:0]      row_req, col_req, dim_in;
  logic [AW-1:0]   bram_addr;
  logic [DW-1:0]   bram_data;
  logic [N*DW-1:0] matA_row, matB_col;
  logic            val_rows, busy, req_dropped;
  logic [5:0]      row_in, col_in;

  mat_fetch_sched #(.N(N), .DW(DW), .AW(AW), .BRAM_LAT(LAT)) dut (
    .clk_in(clk), .rst_in(rst), .new_request(new_request), .row_req(row_req),
    .col_req(col_req), .dim_in(dim_in), .flush(flush), .bram_addr(bram_addr),
    .bram_data(bram_data), .matA_row(matA_row), .matB_col(matB_col),
    .val_rows(val_rows), .row_in(row_in), .col_in(col_in), .busy(busy),
    .req_dropped(req_dropped)
  );

  always #5 clk = ~clk;

  // Synchronous BRAM with LAT cycles from address to data.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[bram_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_data = rd_pipe[LAT-1];

  int n_pass = 0, n_total = 0;

  // Reference model state: what the sequencer should remember between requests.
  bit              m_reuse = 1'b0;
  int              m_last  = 0;
  logic [N*DW-1:0] m_matA  = '0;

  typedef struct {
    int row; int col; int dim; bit fl; int inj; int lat;
  } vec_t;
  vec_t tbl [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_vec(input string nm, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // inj: 0 none, 1 extra request in first ISSUE_B cycle, 2 flush mid-fetch,
  // 3 flush coincident with the val_rows cycle.
  task automatic fetch(input int r, input int c, input int d, input bit fl,
                       input int inj, input int lat);
    bit reuse, addr_ok, busy_ok;
    int f, vfirst, vcount, dcount, bad_a, bad_e;
    int exp_addr[$];
    logic [N*DW-1:0] ea, eb, ga, gb;
    logic [5:0] grow, gcol;
    logic busy_after;
    if (fl) begin
      flush = 1'b1; step(); flush = 1'b0;
      m_reuse = 1'b0;
    end
    reuse = m_reuse && (m_last == r);
    f = reuse ? d : 2 * d;
    if (!reuse) for (int k = 0; k < d; k++) exp_addr.push_back((r * N + k) & AMASK);
    for (int k = 0; k < d; k++) exp_addr.push_back((N * N + k * N + c) & AMASK);
    ea = '0; eb = '0;
    for (int k = 0; k < N; k++) begin
      if (reuse) ea[k*DW +: DW] = m_matA[k*DW +: DW];
      else if (k < d) ea[k*DW +: DW] = mem[(r * N + k) & AMASK];
      if (k < d) eb[k*DW +: DW] = mem[(N * N + k * N + c) & AMASK];
    end
    addr_ok = 1'b1; busy_ok = 1'b1; vfirst = -1; vcount = 0; dcount = 0;
    bad_a = 0; bad_e = 0; ga = '0; gb = '0; grow = '0; gcol = '0;
    new_request = 1'b1; row_req = 6'(r); col_req = 6'(c); dim_in = 6'(d);
    step();
    for (int cy = 1; cy <= lat + 1; cy++) begin
      if (cy <= f && addr_ok && ({21'b0, bram_addr} !== 32'(exp_addr[cy-1]))) begin
        addr_ok = 1'b0; bad_a = int'(bram_addr); bad_e = exp_addr[cy-1];
      end
      if (val_rows === 1'b1) begin
        vcount++;
        if (vfirst < 0) begin
          vfirst = cy; ga = matA_row; gb = matB_col; grow = row_in; gcol = col_in;
        end
      end
      if (req_dropped === 1'b1) dcount++;
      if (cy <= lat && busy !== 1'b1) busy_ok = 1'b0;
      busy_after = busy;
      row_req = 6'($urandom); col_req = 6'($urandom); dim_in = 6'($urandom_range(1, 63));
      new_request = (inj == 1 && cy == (reuse ? 1 : d + 1));
      flush = (inj == 2 && cy == 2) || (inj == 3 && cy == lat);
      if (cy <= lat) step();
    end
    new_request = 1'b0; flush = 1'b0;
    chk(addr_ok, "addr_seq", bad_a, bad_e);
    chk(vfirst == lat, "val_cycle", vfirst, lat);
    chk(vcount == 1, "val_count", vcount, 1);
    chk_vec("matA_row", ga, ea);
    chk_vec("matB_col", gb, eb);
    chk(grow == 6'(r) && gcol == 6'(c), "row_col_echo", {grow, gcol}, {6'(r), 6'(c)});
    chk(busy_ok, "busy_hold", 0, 1);
    chk(busy_after === 1'b0, "busy_after", busy_after, 0);
    chk(dcount == (inj == 1 ? 1 : 0), "drop_count", dcount, (inj == 1 ? 1 : 0));
    m_reuse = (inj != 2 && inj != 3);
    m_last  = r & 63;
    m_matA  = ea;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
    mem[32] = 8'd2; mem[33] = 8'd2; mem[34] = 8'd2;
    mem[1024] = 8'd1; mem[1056] = 8'd0; mem[1088] = 8'd0;

    //            row col dim fl inj lat
    tbl[0]  = '{  1,  0,  3, 0, 0,  9};
    tbl[1]  = '{  1,  1,  3, 0, 0,  6};
    tbl[2]  = '{  1,  2,  3, 1, 0,  9};
    tbl[3]  = '{  2,  0,  3, 0, 1,  9};
    tbl[4]  = '{  2,  1,  3, 0, 2,  6};
    tbl[5]  = '{  2,  1,  3, 0, 0,  9};
    tbl[6]  = '{ 31, 31, 32, 0, 0, 67};
    tbl[7]  = '{ 31,  5, 32, 0, 0, 35};
    tbl[8]  = '{  0,  0,  1, 0, 0,  5};
    tbl[9]  = '{  0,  3,  1, 0, 0,  4};
    tbl[10] = '{  0,  4,  1, 0, 3,  4};
    tbl[11] = '{  0,  5,  1, 0, 0,  5};

    rst = 1'b1; new_request = 1'b0; flush = 1'b0;
    row_req = '0; col_req = '0; dim_in = '0;
    step(); step();
    rst = 1'b0;
    chk(busy === 1'b0 && val_rows === 1'b0 && req_dropped === 1'b0, "reset_ctrl",
        {busy, val_rows, req_dropped}, 0);
    chk(bram_addr === '0 && row_in === '0 && col_in === '0, "reset_idx",
        {bram_addr, row_in, col_in}, 0);
    chk_vec("reset_matA", matA_row, '0);
    chk_vec("reset_matB", matB_col, '0);

    for (int i = 0; i < 12; i++)
      fetch(tbl[i].row, tbl[i].col, tbl[i].dim, tbl[i].fl, tbl[i].inj, tbl[i].lat);

    // Zero-dimension request is rejected from IDLE with a single pulse.
    new_request = 1'b1; row_req = 6'd3; col_req = 6'd3; dim_in = 6'd0;
    step();
    new_request = 1'b0;
    chk(req_dropped === 1'b1, "drop_dim0", req_dropped, 1);
    chk(busy === 1'b0, "idle_after_dim0", busy, 0);
    step();
    chk(req_dropped === 1'b0, "drop_pulse_len", req_dropped, 0);

    // Reset during DRAIN aborts the fetch and forgets the reusable row.
    fetch(0, 0, 3, 1'b1, 0, 9);
    new_request = 1'b1; row_req = 6'd5; col_req = 6'd0; dim_in = 6'd3;
    step();
    new_request = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk(busy === 1'b0 && val_rows === 1'b0 && bram_addr === '0, "rst_mid_ctrl",
        {busy, val_rows, bram_addr}, 0);
    chk_vec("rst_mid_matA", matA_row, '0);
    chk_vec("rst_mid_matB", matB_col, '0);
    vc = 0;
    for (int i = 0; i < 8; i++) begin
      if (val_rows === 1'b1) vc++;
      step();
    end
    chk(vc == 0, "no_val_after_rst", vc, 0);
    m_reuse = 1'b0; m_matA = '0;
    fetch(0, 0, 3, 1'b0, 0, 9);

    for (int it = 0; it < 30; it++) begin
      int d, r, c, inj, f, lat;
      bit fl, reuse;
      d   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 32) : $urandom_range(1, 6);
      r   = $urandom_range(0, 1) ? m_last : $urandom_range(0, 63);
      c   = $urandom_range(0, 63);
      fl  = ($urandom_range(0, 4) == 0);
      inj = $urandom_range(0, 3);
      reuse = !fl && m_reuse && (m_last == r);
      f   = reuse ? d : 2 * d;
      lat = f + LAT + 1;
      fetch(r, c, d, fl, inj, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
